// File: rtl/arb_rr_n.sv
// N-requester round-robin arbiter: registered one-hot grant, grant parking, bounded tenure.
// Optional build macro ARB_RR_PRIO_EN adds a per-requester high-priority input hp.
module arb_rr_n #(
    parameter  int NREQ     = 4,
    parameter  int MAX_HOLD = 8,
    localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
`ifdef ARB_RR_PRIO_EN
    input  logic [NREQ-1:0] hp,
`endif
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            gnt_vld
);

    localparam int             HCW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;
    localparam logic [IDW-1:0] LAST_ID   = IDW'(NREQ - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [HCW-1:0]  hold_cnt;

    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] cand;
    logic [NREQ-1:0] win_oh;
    logic [IDW-1:0]  win_id;
    logic [IDW-1:0]  win_next;
    logic            own_req;
    logic            at_limit;
    logic            take;
    logic            drop;

    // First set bit of v in the order start, start+1, ..., wrapping at NREQ.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                               input logic [IDW-1:0]  start);
        logic [IDW-1:0] idx;
        logic           found;
        int             j;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(start) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!found && v[j]) begin
                found = 1'b1;
                idx   = IDW'(j);
            end
        end
        return idx;
    endfunction

    // NOTE: every output of this block gets a value on every path, so no latch is inferred.
    always_comb begin
        pend = (state == GRANT) ? (req & ~gnt) : req;
`ifdef ARB_RR_PRIO_EN
        cand = (|(pend & hp)) ? (pend & hp) : pend;
`else
        cand = pend;
`endif
        // ptr always sits one past the owner during a tenure, so one search start serves all cases.
        win_id   = rr_pick(cand, ptr);
        win_next = (win_id == LAST_ID) ? '0 : win_id + IDW'(1);
        win_oh   = '0;
        win_oh[win_id] = 1'b1;
        own_req  = |(req & gnt);
        at_limit = (MAX_HOLD > 0) && (hold_cnt == HOLD_LAST);
        take     = (state == IDLE) ? (|req) : ((!own_req || at_limit) && (|pend));
        drop     = (state == GRANT) && !own_req && !(|pend);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            gnt_vld  <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        state    <= GRANT;
                        gnt      <= win_oh;
                        gnt_id   <= win_id;
                        gnt_vld  <= 1'b1;
                        ptr      <= win_next;
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (take) begin
                        gnt      <= win_oh;
                        gnt_id   <= win_id;
                        ptr      <= win_next;
                        hold_cnt <= '0;
                    end else if (drop) begin
                        state    <= IDLE;
                        gnt      <= '0;
                        gnt_id   <= '0;
                        gnt_vld  <= 1'b0;
                        hold_cnt <= '0;
                    end else if (at_limit || MAX_HOLD == 0) begin
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HCW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arb_rr_n.sv
// Directed self-checking bench for arb_rr_n: reset, rotation, release, parking, wrap,
// bounded tenure (MAX_HOLD=4, with hp when ARB_RR_PRIO_EN is defined) and NREQ=1.
module tb_arb_rr_n;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] hp;
    logic [0:0] req1;

    logic [3:0] gnt, gnt4;
    logic [1:0] gnt_id, gnt_id4;
    logic       gnt_vld, gnt_vld4;
    logic [0:0] gnt1;
    logic [0:0] gnt_id1;
    logic       gnt_vld1;

    logic [3:0] req_q;
    int         pass_cnt = 0;
    int         total    = 0;

    always #5 clk = ~clk;

    arb_rr_n #(.NREQ(4), .MAX_HOLD(8)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
`ifdef ARB_RR_PRIO_EN
        .hp      (hp),
`endif
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld)
    );

    arb_rr_n #(.NREQ(4), .MAX_HOLD(4)) u_dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
`ifdef ARB_RR_PRIO_EN
        .hp      (hp),
`endif
        .gnt     (gnt4),
        .gnt_id  (gnt_id4),
        .gnt_vld (gnt_vld4)
    );

    arb_rr_n #(.NREQ(1), .MAX_HOLD(2)) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req1),
`ifdef ARB_RR_PRIO_EN
        .hp      (1'b0),
`endif
        .gnt     (gnt1),
        .gnt_id  (gnt_id1),
        .gnt_vld (gnt_vld1)
    );

    // Per-cycle invariants: one-hot-or-zero, gnt_vld tracks |gnt, grant only to a requester seen at the edge.
    always @(posedge clk) req_q <= req;

    always @(negedge clk) begin
        total++;
        if (!$onehot0(gnt) || gnt_vld !== (|gnt) || (gnt & ~req_q) !== 4'b0000)
            $display("FAIL inv_main t=%0t gnt=%b vld=%b req_q=%b", $time, gnt, gnt_vld, req_q);
        else
            pass_cnt++;
        total++;
        if (!$onehot0(gnt4) || gnt_vld4 !== (|gnt4) || (gnt4 & ~req_q) !== 4'b0000)
            $display("FAIL inv_hold4 t=%0t gnt=%b vld=%b req_q=%b", $time, gnt4, gnt_vld4, req_q);
        else
            pass_cnt++;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        hp    = 4'b0000;
        req1  = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        hp    = 4'b0000;
        req1  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || gnt_id !== 2'd0 || gnt4 !== 4'b0000 || gnt1 !== 1'b0)
                $display("FAIL reset_hold cyc=%0d got gnt=%b vld=%b id=%0d gnt4=%b gnt1=%b want all zero",
                         i, gnt, gnt_vld, gnt_id, gnt4, gnt1);
            else
                pass_cnt++;
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0 || gnt_vld !== 1'b1)
            $display("FAIL reset_first_grant got gnt=%b id=%0d vld=%b want 0001/0/1", gnt, gnt_id, gnt_vld);
        else
            pass_cnt++;
    endtask

    // Continues from test_reset: cycle 0 of owner 0 was already observed.
    task automatic test_rotation();
        logic [1:0] exp_id;
        logic [3:0] exp_gnt;
        for (int c = 1; c < 40; c++) begin
            tick();
            exp_id  = 2'((c / 8) % 4);
            exp_gnt = 4'b0001 << exp_id;
            total++;
            if (gnt !== exp_gnt || gnt_id !== exp_id)
                $display("FAIL rotation cyc=%0d got gnt=%b id=%0d want %b/%0d", c, gnt, gnt_id, exp_gnt, exp_id);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_release();
        logic [3:0] stim [4] = '{4'b0100, 4'b0101, 4'b0001, 4'b0000};
        logic [3:0] want [4] = '{4'b0100, 4'b0100, 4'b0001, 4'b0000};
        logic [1:0] wid  [4] = '{2'd2, 2'd2, 2'd0, 2'd0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req = stim[i];
            tick();
            total++;
            if (gnt !== want[i] || gnt_id !== wid[i] || gnt_vld !== (want[i] != 4'b0000))
                $display("FAIL release step=%0d got gnt=%b id=%0d vld=%b want %b/%0d",
                         i, gnt, gnt_id, gnt_vld, want[i], wid[i]);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_parking();
        do_reset();
        req = 4'b0010;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (gnt !== 4'b0010 || gnt_id !== 2'd1)
                $display("FAIL parking cyc=%0d got gnt=%b id=%0d want 0010/1", i, gnt, gnt_id);
            else
                pass_cnt++;
        end
        req = 4'b0000;
        tick();
        // ptr was left at 2 by the grant to 1; search 2,3,0 picks 0.
        req = 4'b0011;
        tick();
        total++;
        if (gnt !== 4'b0001)
            $display("FAIL parking_ptr got gnt=%b want 0001", gnt);
        else
            pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [3:0] stim [4] = '{4'b1000, 4'b0101, 4'b0100, 4'b0000};
        logic [3:0] want [4] = '{4'b1000, 4'b0001, 4'b0100, 4'b0000};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req = stim[i];
            tick();
            total++;
            if (gnt !== want[i])
                $display("FAIL wrap step=%0d got gnt=%b want %b", i, gnt, want[i]);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_hold4();
        logic [3:0] next1, next2;
`ifdef ARB_RR_PRIO_EN
        next1 = 4'b1000;
        next2 = 4'b0001;
`else
        next1 = 4'b0010;
        next2 = 4'b0100;
`endif
        do_reset();
        req = 4'b0001;
        hp  = 4'b1000;
        tick();
        total++;
        if (gnt4 !== 4'b0001)
            $display("FAIL hold4_start got gnt=%b want 0001", gnt4);
        else
            pass_cnt++;
        req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (gnt4 !== 4'b0001)
                $display("FAIL hold4_keep0 cyc=%0d got gnt=%b want 0001", i, gnt4);
            else
                pass_cnt++;
        end
        tick();
        total++;
        if (gnt4 !== next1)
            $display("FAIL hold4_rot1 got gnt=%b want %b", gnt4, next1);
        else
            pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (gnt4 !== next1)
                $display("FAIL hold4_keep1 cyc=%0d got gnt=%b want %b", i, gnt4, next1);
            else
                pass_cnt++;
        end
        tick();
        total++;
        if (gnt4 !== next2)
            $display("FAIL hold4_rot2 got gnt=%b want %b", gnt4, next2);
        else
            pass_cnt++;
    endtask

    task automatic test_nreq1();
        logic [0:0] stim [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            req1 = stim[i];
            tick();
            total++;
            if (gnt1 !== stim[i] || gnt_vld1 !== stim[i][0] || gnt_id1 !== 1'b0)
                $display("FAIL nreq1 step=%0d got gnt=%b vld=%b id=%0d want %b",
                         i, gnt1, gnt_vld1, gnt_id1, stim[i]);
            else
                pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_release();
        test_parking();
        test_wrap();
        test_hold4();
        test_nreq1();
        tick(2);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
